// File: rtl/seq_array_divider.sv
// Sequential restoring divider: one shift/subtract step per clock, start/busy/done handshake.
// A zero divisor produces all-ones quotient and remainder plus the div_by_zero flag.
module seq_array_divider #(
    parameter int WIDTH_N = 8,
    parameter int WIDTH_D = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_N-1:0] dividend,
    input  logic [WIDTH_D-1:0] divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_N-1:0] quotient,
    output logic [WIDTH_D-1:0] remainder,
    output logic               div_by_zero
);
    localparam int CW = $clog2(WIDTH_N + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [WIDTH_N-1:0] wq_q, wq_d;
    logic [WIDTH_D:0]   r_q, r_d;
    logic [WIDTH_D-1:0] dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH_N-1:0] quot_q, quot_d;
    logic [WIDTH_D-1:0] rem_q, rem_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH_D:0]   r_sh, r_nx;
    logic [WIDTH_N-1:0] q_nx;
    logic               ge;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        r_sh = {r_q[WIDTH_D-1:0], wq_q[WIDTH_N-1]};
        ge   = (r_sh >= {1'b0, dvs_q});
        r_nx = ge ? (r_sh - {1'b0, dvs_q}) : r_sh;
        q_nx = {wq_q[WIDTH_N-2:0], ge};
    end

    always_comb begin
        state_d = state_q;
        wq_d    = wq_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wq_d    = dividend;
                    dvs_d   = divisor;
                    r_d     = '0;
                    cnt_d   = CW'(WIDTH_N);
                    state_d = CALC;
                end
            end
            CALC: begin
                wq_d  = q_nx;
                r_d   = r_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    if (dvs_q == '0) begin
                        quot_d = '1;
                        rem_d  = '1;
                        dbz_d  = 1'b1;
                    end else begin
                        quot_d = q_nx;
                        rem_d  = r_nx[WIDTH_D-1:0];
                        dbz_d  = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wq_q    <= '0;
            r_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wq_q    <= wq_d;
            r_q     <= r_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_array_divider.sv
// Self-checking bench for seq_array_divider: directed, randomized and exhaustive operands
// against plain-arithmetic division, plus handshake timing and reset behaviour.
module tb_seq_array_divider;
    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [D-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [N-1:0] quotient;
    logic [D-1:0] remainder;

    int checks = 0;
    int failures = 0;

    seq_array_divider #(.WIDTH_N(N), .WIDTH_D(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer division, with the all-ones convention for a zero divisor.
    function automatic void model(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << N) - 1; r = (1 << D) - 1; z = 1;
        end else begin
            q = a / b; r = a % b; z = 0;
        end
    endfunction

    task automatic check_result(input string tag, input int a, input int b);
        int q, r, z;
        model(a, b, q, r, z);
        chk({tag, "_q"}, quotient, q);
        chk({tag, "_r"}, remainder, r);
        chk({tag, "_dbz"}, div_by_zero, z);
        if (b != 0) chk({tag, "_inv"}, (int'(quotient) * b + int'(remainder) == a) && (int'(remainder) < b), 1);
    endtask

    // Launch one divide, optionally disturbing inputs and start throughout CALC and DONE.
    task automatic run_op(input string tag, input int a, input int b, input bit scramble);
        int bc;
        @(posedge clk); #1;
        start = 1'b1; dividend = N'(a); divisor = D'(b);
        @(posedge clk); #1;
        start = 1'b0;
        bc = 0;
        forever begin
            @(negedge clk);
            if (!busy || bc > 20) break;
            bc++;
            if (scramble) begin
                start = 1'($urandom); dividend = N'($urandom); divisor = D'($urandom);
            end
        end
        chk({tag, "_busy_cycles"}, bc, N);
        chk({tag, "_done"}, done, 1);
        check_result(tag, a, b);
        if (scramble) start = 1'b1;  // start during the DONE cycle must be ignored
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_width"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int acc_a, acc_b, last_acc, seen;
        bit prev_busy, have_acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);

        // Directed cases
        run_op("basic", 200, 7, 0);
        run_op("b255_15", 255, 15, 0);
        run_op("b255_1", 255, 1, 0);
        run_op("b5_9", 5, 9, 0);
        run_op("b0_3", 0, 3, 0);
        run_op("dbz", 13, 0, 0);
        run_op("after_dbz", 12, 4, 0);

        // Outputs hold while a later divide is in CALC
        @(posedge clk); #1;
        start = 1'b1; dividend = 8'd100; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_q", quotient, 3);
        chk("hold_r", remainder, 0);

        // Reset in the middle of CALC
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        chk("midrst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("midrst_no_done", seen, 0);

        // Randomized operands with inputs disturbed after acceptance
        for (int i = 0; i < 40; i++)
            run_op("rand", int'($urandom_range(255)), int'($urandom_range(15)), 1);

        // start held high continuously with operands changing every cycle
        start = 1'b1; dividend = N'($urandom); divisor = D'($urandom);
        prev_busy = busy; have_acc = 0; last_acc = -1; acc_a = 0; acc_b = 0;
        for (int c = 0; c < 65; c++) begin
            @(negedge clk);
            if (busy && !prev_busy) begin
                acc_a = int'(dividend); acc_b = int'(divisor); have_acc = 1;
                if (last_acc >= 0) chk("acc_spacing", c - last_acc, N + 2);
                last_acc = c;
            end
            if (done && have_acc) check_result("cont", acc_a, acc_b);
            prev_busy = busy;
            dividend = N'($urandom); divisor = D'($urandom);
        end
        start = 1'b0;
        seen = 0;
        while ((busy || done) && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        chk("cont_drain", (busy || done), 0);

        // Exhaustive operand sweep
        for (int a = 0; a < (1 << N); a++)
            for (int b = 0; b < (1 << D); b++)
                run_op("exh", a, b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_array_divider.md
Name: seq_array_divider

Overview:
- Sequential restoring divider, the inverse of the team's combinational 4x4 array multiplier.
- Takes an unsigned WIDTH_N-bit dividend and an unsigned WIDTH_D-bit divisor. Produces quotient and remainder using one shift/subtract step per clock.
- Sits beside the multiplier in the Tiny Tapeout arithmetic tile. Its start/busy/done handshake is driven by the tile's top-level control.
- Default sizing (8/4) exactly inverts the multiplier: any 8-bit product divided by a 4-bit operand.

Parameters:
- WIDTH_N, 8: dividend and quotient width in bits; also the number of compute steps.
- WIDTH_D, 4: divisor and remainder width in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  WIDTH_N  unsigned dividend; captured on accepted start.
- divisor  input  WIDTH_D  unsigned divisor; captured on accepted start.
- busy  output  1  high while computing (CALC state).
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  WIDTH_N  registered quotient.
- remainder  output  WIDTH_D  registered remainder.
- div_by_zero  output  1  registered; high with the result if captured divisor was 0.

Behaviour:
- Reset (rst_n low, any time including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and working registers are cleared.
  - Operation resumes on the first clk edge after rst_n is released.
- States: IDLE, CALC, DONE. No other states. Any unreachable encoding returns to IDLE.
- IDLE:
  - If start=1 at edge k: capture dividend into the working quotient shift register and divisor into the divisor register.
  - Clear the WIDTH_D+1-bit partial remainder, load step counter = WIDTH_N, go to CALC.
  - busy=1 from edge k.
- CALC, one step per edge:
  - Partial remainder R = {R[WIDTH_D-1:0], Q msb}; Q shifted left by 1.
  - If R >= divisor: R = R - divisor and Q lsb = 1; else Q lsb = 0.
  - Counter decrements.
  - The step on edge k+WIDTH_N is the last. On that same edge the block goes to DONE, loads quotient/remainder/div_by_zero outputs, sets done=1 and busy=0.
- DONE: lasts exactly one cycle; done=1. The next edge returns to IDLE and sets done=0.
- Latency:
  - busy high for exactly WIDTH_N cycles.
  - done high for the single cycle immediately after busy falls.
  - Earliest next accepted start is edge k+WIDTH_N+2.
- start while in CALC or DONE is ignored, with no effect on state or captured operands.
- Outputs hold their last result until the next done. They do not change during CALC.
- Divide by zero (captured divisor = 0):
  - Same timing as a normal divide.
  - Result: quotient = all ones, remainder = all ones, div_by_zero=1.
- div_by_zero is cleared (0) with every non-zero-divisor result.
- dividend < divisor: quotient=0, remainder=dividend (fits in WIDTH_D bits).
- Invariant for divisor != 0: quotient*divisor + remainder == dividend, and remainder < divisor.
- Input changes after acceptance do not affect the result.

Test Plan:
- Reset: hold rst_n low, then release → busy=0, done=0, quotient=0x00, remainder=0x0, div_by_zero=0. Assert rst_n low 3 cycles into CALC → all outputs return to 0 immediately, state IDLE, no done pulse follows.
- Basic: start with dividend=200, divisor=7 at edge k → busy high for 8 cycles; done pulse after edge k+8 with quotient=28, remainder=4, div_by_zero=0.
- Boundary values: 255/15 → quotient=17, remainder=0. 255/1 → quotient=255, remainder=0. 5/9 → quotient=0, remainder=5. 0/3 → quotient=0, remainder=0.
- Divide by zero: 13/0 → done after 8 busy cycles with quotient=0xFF, remainder=0xF, div_by_zero=1. Follow-up 12/4 → quotient=3, remainder=0, div_by_zero=0.
- Handshake:
  - Assert start every cycle with changing operands → only starts sampled in IDLE are accepted (every 10 edges). Each result matches the operands present at its accepting edge.
  - Change dividend/divisor mid-CALC → result unaffected.
  - start during the DONE cycle is ignored.
- Exhaustive: all 256×16 operand pairs back-to-back → quotient*divisor+remainder==dividend and remainder<divisor for every divisor≠0. All divisor=0 cases flag div_by_zero. Every done is exactly 1 cycle wide.
